vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Recovers pixel coordinates from asynchronous, active-low hsync/vsync.
// Line and frame lengths are measured. Lock is declared only after one full
// frame shows a consistent line length. The next vsync must also confirm
// the frame length.
//
// Ports
//   clk          pixel clock, all logic on its rising edge
//   reset        asynchronous, active-high reset
//   hys, vys     active-low sync pulses, asynchronous to clk
//   rgb_r/g/b    pixel colour bits
//   px_x, px_y   registered horizontal / vertical counts
//   de           registered data enable (active window and locked)
//   pix_r/g/b    colour aligned with px_x/px_y, forced 0 when de=0
//   locked       1 exactly while the FSM is in LOCKED
//   line_len     clocks per line, taken from the last completed line
//   frame_lines  lines per frame, taken from the last completed frame
//   lock_lost    one-cycle pulse on the LOCKED-to-SEARCH transition
//   dbg_state    current FSM state (0 SEARCH, 1 MEASURE, 2 LOCKED)
//
// Flow semantics: a pure streaming sink/source with no valid/ready
// handshake. de acts as the valid qualifier for px_x/px_y/pix_*, and
// there is no backpressure.
module vga_sync_decoder #(
  parameter int H_ACT_START = 114,
  parameter int H_ACT_END   = 784,
  parameter int V_ACT_START = 34,
  parameter int V_ACT_END   = 630
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hys,
  input  logic        vys,
  input  logic        rgb_r,
  input  logic        rgb_g,
  input  logic        rgb_b,
  output logic [9:0]  px_x,
  output logic [10:0] px_y,
  output logic        de,
  output logic        pix_r,
  output logic        pix_g,
  output logic        pix_b,
  output logic        locked,
  output logic [9:0]  line_len,
  output logic [10:0] frame_lines,
  output logic        lock_lost,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [9:0]  HA_S = 10'(H_ACT_START);
  localparam logic [9:0]  HA_E = 10'(H_ACT_END);
  localparam logic [10:0] VA_S = 11'(V_ACT_START);
  localparam logic [10:0] VA_E = 11'(V_ACT_END);

  state_t      state;
  logic [2:0]  hs_sr;   // [0],[1] synchroniser, [2] history
  logic [2:0]  vs_sr;
  logic [2:0]  r_dly, g_dly, b_dly;
  logic [9:0]  h_cnt;
  logic [10:0] v_cnt;
  logic        line_ok;

  logic        hf, vf;
  logic        h_sat, v_sat;
  logic [9:0]  new_len;
  logic [10:0] new_frame;
  logic        len_mis, frame_mis, drop, in_win, de_n;

  assign dbg_state = state;

  // Falling edge: history still high, synchronised value now low.
  assign hf = hs_sr[2] & ~hs_sr[1];
  assign vf = vs_sr[2] & ~vs_sr[1];

  assign h_sat     = (h_cnt == 10'd1023);
  assign v_sat     = (v_cnt == 11'd2047);
  assign new_len   = h_sat ? 10'd1023 : h_cnt + 10'd1;
  assign new_frame = v_sat ? 11'd2047 : v_cnt + 11'd1;
  assign len_mis   = hf && (new_len != line_len);
  assign frame_mis = (new_frame != frame_lines);

  // Loss condition evaluated in LOCKED. It also masks de on the very edge
  // that leaves LOCKED, so de never shows 1 while locked reads 0.
  assign drop = (state == LOCKED) &&
                (len_mis || (vf && frame_mis) || h_sat || v_sat);

  assign in_win = (h_cnt >= HA_S) && (h_cnt < HA_E) &&
                  (v_cnt >= VA_S) && (v_cnt < VA_E);
  assign de_n   = (state == LOCKED) && !drop && in_win;

  // Synchronisers (idle-high) and colour delay line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_sr <= 3'b111;
      vs_sr <= 3'b111;
      r_dly <= 3'b000;
      g_dly <= 3'b000;
      b_dly <= 3'b000;
    end else begin
      hs_sr <= {hs_sr[1:0], hys};
      vs_sr <= {vs_sr[1:0], vys};
      r_dly <= {r_dly[1:0], rgb_r};
      g_dly <= {g_dly[1:0], rgb_g};
      b_dly <= {b_dly[1:0], rgb_b};
    end
  end

  // Free-running counters and line length measurement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt    <= 10'd0;
      v_cnt    <= 11'd0;
      line_len <= 10'd0;
    end else begin
      if (hf) begin
        h_cnt    <= 10'd0;
        line_len <= new_len;
      end else if (!h_sat) begin
        h_cnt <= h_cnt + 10'd1;
      end
      if (vf)
        v_cnt <= 11'd0;
      else if (hf && !v_sat)
        v_cnt <= v_cnt + 11'd1;
    end
  end

  // Lock FSM with registered locked / lock_lost / frame_lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      line_ok     <= 1'b0;
      frame_lines <= 11'd0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      case (state)
        SEARCH: begin
          if (vf) begin
            state   <= MEASURE;
            line_ok <= 1'b1;
          end
        end
        MEASURE: begin
          if (vf) begin
            frame_lines <= new_frame;
            // The line closing on this same edge must also match.
            if (line_ok && !len_mis && !h_sat && !v_sat) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              line_ok <= 1'b1;
            end
          end else if (len_mis || h_sat || v_sat) begin
            line_ok <= 1'b0;
          end
        end
        LOCKED: begin
          if (vf)
            frame_lines <= new_frame;
          if (drop) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            lock_lost <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: coordinates, enable and colour registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_x  <= 10'd0;
      px_y  <= 11'd0;
      de    <= 1'b0;
      pix_r <= 1'b0;
      pix_g <= 1'b0;
      pix_b <= 1'b0;
    end else begin
      px_x  <= h_cnt;
      px_y  <= v_cnt;
      de    <= de_n;
      pix_r <= de_n & r_dly[2];
      pix_g <= de_n & g_dly[2];
      pix_b <= de_n & b_dly[2];
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
// Directed bench for vga_sync_decoder using a scaled-down video timing:
// 40-clock lines (4-clock hsync low) and 20-line frames (2-line vsync low).
// The active window is h 8..31 and v 3..16, so a locked frame holds
// 24 * 14 = 336 enabled pixels.
// A generator process drives hys/vys on the falling clock edge. It records
// the cycle of every vsync falling edge it produces.
// From that drive, locked rises 3 rising edges later: two synchroniser
// stages, then the state update.
module tb_vga_sync_decoder;

  localparam int H_ACT_START = 8;
  localparam int H_ACT_END   = 32;
  localparam int V_ACT_START = 3;
  localparam int V_ACT_END   = 17;
  localparam int HSYNC_W     = 4;
  localparam int VSYNC_W     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        hys, vys;
  logic        rgb_r, rgb_g, rgb_b;
  logic [9:0]  px_x, line_len;
  logic [10:0] px_y, frame_lines;
  logic        de, pix_r, pix_g, pix_b, locked, lock_lost;
  logic [1:0]  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // Generator controls and bookkeeping
  int gen_len   = 40;
  int gen_frame = 20;
  int short_at  = -1;
  int short_len = 30;
  bit gen_on    = 1'b0;
  bit hold_h    = 1'b0;
  int hc = 0;
  int vc = 0;
  int vfall_cnt = 0;
  int vfall_cyc = 0;
  int cyc       = 0;
  bit v_new;

  vga_sync_decoder #(
    .H_ACT_START(H_ACT_START),
    .H_ACT_END  (H_ACT_END),
    .V_ACT_START(V_ACT_START),
    .V_ACT_END  (V_ACT_END)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hys        (hys),
    .vys        (vys),
    .rgb_r      (rgb_r),
    .rgb_g      (rgb_g),
    .rgb_b      (rgb_b),
    .px_x       (px_x),
    .px_y       (px_y),
    .de         (de),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .locked     (locked),
    .line_len   (line_len),
    .frame_lines(frame_lines),
    .lock_lost  (lock_lost),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- sync generator ----------------
  initial begin
    hys = 1'b1;
    vys = 1'b1;
    forever begin
      @(negedge clk);
      if (gen_on) begin
        hys   = hold_h ? 1'b1 : (hc >= HSYNC_W);
        v_new = (vc >= VSYNC_W);
        if (vys && !v_new) begin
          vfall_cnt++;
          vfall_cyc = cyc;
        end
        vys = v_new;
        hc++;
        if (hc >= ((vc == short_at) ? short_len : gen_len)) begin
          if (vc == short_at) short_at = -1;
          hc = 0;
          vc++;
          if (vc >= gen_frame) vc = 0;
        end
      end
    end
  end

  // ---------------- wait helpers ----------------
  task automatic wait_vfall(input int budget, output bit timed_out);
    int base;
    base = vfall_cnt;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (vfall_cnt != base) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_locked(input int budget, output int lock_vf,
                             output int lock_delta, output bit timed_out);
    timed_out  = 1'b1;
    lock_vf    = -1;
    lock_delta = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (locked) begin
        lock_vf    = vfall_cnt;
        lock_delta = cyc - vfall_cyc;
        timed_out  = 1'b0;
        break;
      end
    end
  endtask

  // Runs until locked returns after a lock_lost pulse, gathering stats.
  task automatic watch_relock(input int budget, output int lost_n,
                              output int lost_vf, output int lost_delta,
                              output int lock_at_lost, output int relock_vf,
                              output int relock_delta, output int de_bad,
                              output bit timed_out);
    bit seen_lost;
    seen_lost    = 1'b0;
    lost_n       = 0;
    lost_vf      = -1;
    lost_delta   = -1;
    lock_at_lost = -1;
    relock_vf    = -1;
    relock_delta = -1;
    de_bad       = 0;
    timed_out    = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (lock_lost) begin
        lost_n++;
        if (!seen_lost) begin
          seen_lost    = 1'b1;
          lost_vf      = vfall_cnt;
          lost_delta   = cyc - vfall_cyc;
          lock_at_lost = int'(locked);
        end
      end else if (seen_lost && locked) begin
        relock_vf    = vfall_cnt;
        relock_delta = cyc - vfall_cyc;
        timed_out    = 1'b0;
        break;
      end
      if (seen_lost && !locked && de) de_bad++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (px_x !== 10'd0) begin tests_failed++; $display("FAIL reset_px_x: got %0d expected 0", px_x); end
    tests_run++; if (px_y !== 11'd0) begin tests_failed++; $display("FAIL reset_px_y: got %0d expected 0", px_y); end
    tests_run++; if (de !== 1'b0) begin tests_failed++; $display("FAIL reset_de: got %b expected 0", de); end
    tests_run++; if ({pix_r, pix_g, pix_b} !== 3'b000) begin tests_failed++; $display("FAIL reset_pix: got %b expected 000", {pix_r, pix_g, pix_b}); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked: got %b expected 0", locked); end
    tests_run++; if (lock_lost !== 1'b0) begin tests_failed++; $display("FAIL reset_lock_lost: got %b expected 0", lock_lost); end
    tests_run++; if (line_len !== 10'd0) begin tests_failed++; $display("FAIL reset_line_len: got %0d expected 0", line_len); end
    tests_run++; if (frame_lines !== 11'd0) begin tests_failed++; $display("FAIL reset_frame_lines: got %0d expected 0", frame_lines); end
    tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // h_cnt runs from 0 after release; px_x trails it by one register.
    tests_run++; if (px_x !== 10'd3) begin tests_failed++; $display("FAIL release_px_x: got %0d expected 3", px_x); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL release_locked: got %b expected 0", locked); end
  endtask

  task automatic test_lock();
    bit to;
    int lvf, ldel, base;
    gen_len   = 40;
    gen_frame = 20;
    hc        = 0;
    vc        = 17;
    base      = vfall_cnt;
    gen_on    = 1'b1;
    wait_vfall(1000, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL lock_first_vf: got timeout expected vsync edge"); end
    repeat (5) @(posedge clk);
    #1;
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL lock_after_first_vf: got %b expected 0", locked); end
    tests_run++; if (dbg_state !== 2'd1) begin tests_failed++; $display("FAIL state_after_first_vf: got %0d expected 1", dbg_state); end
    wait_locked(2000, lvf, ldel, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL lock_timeout: got timeout expected locked"); end
    tests_run++; if (lvf !== base + 2) begin tests_failed++; $display("FAIL lock_vf_count: got %0d expected %0d", lvf, base + 2); end
    tests_run++; if (ldel !== 3) begin tests_failed++; $display("FAIL lock_latency: got %0d expected 3", ldel); end
    tests_run++; if (line_len !== 10'd40) begin tests_failed++; $display("FAIL lock_line_len: got %0d expected 40", line_len); end
    tests_run++; if (frame_lines !== 11'd20) begin tests_failed++; $display("FAIL lock_frame_lines: got %0d expected 20", frame_lines); end
  endtask

  task automatic test_active_window();
    bit to;
    int de_n, pix_bad, g_bad, unl, lost, min_x, max_x, min_y, max_y;
    de_n = 0; pix_bad = 0; g_bad = 0; unl = 0; lost = 0;
    min_x = 1023; max_x = 0; min_y = 2047; max_y = 0;
    wait_vfall(1000, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL window_vf: got timeout expected vsync edge"); end
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      if (de) begin
        de_n++;
        if (int'(px_x) < min_x) min_x = int'(px_x);
        if (int'(px_x) > max_x) max_x = int'(px_x);
        if (int'(px_y) < min_y) min_y = int'(px_y);
        if (int'(px_y) > max_y) max_y = int'(px_y);
      end
      if (pix_r !== de || pix_b !== de) pix_bad++;
      if (pix_g !== 1'b0) g_bad++;
      if (!locked) unl++;
      if (lock_lost) lost++;
    end
    tests_run++; if (de_n !== 336) begin tests_failed++; $display("FAIL window_de_count: got %0d expected 336", de_n); end
    tests_run++; if (pix_bad !== 0) begin tests_failed++; $display("FAIL window_pix_rb: got %0d mismatching cycles expected 0", pix_bad); end
    tests_run++; if (g_bad !== 0) begin tests_failed++; $display("FAIL window_pix_g: got %0d nonzero cycles expected 0", g_bad); end
    tests_run++; if (min_x !== 8 || max_x !== 31) begin tests_failed++; $display("FAIL window_x_range: got %0d..%0d expected 8..31", min_x, max_x); end
    tests_run++; if (min_y !== 3 || max_y !== 16) begin tests_failed++; $display("FAIL window_y_range: got %0d..%0d expected 3..16", min_y, max_y); end
    tests_run++; if (unl !== 0 || lost !== 0) begin tests_failed++; $display("FAIL window_lock_stable: got %0d unlocked, %0d lost expected 0, 0", unl, lost); end
  endtask

  task automatic test_short_line();
    bit to;
    int ln, lvf, ldel, lat, rvf, rdel, deb;
    wait_vfall(1000, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL short_vf: got timeout expected vsync edge"); end
    short_at  = 5;
    short_len = 30;
    watch_relock(3000, ln, lvf, ldel, lat, rvf, rdel, deb, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL short_relock_timeout: got timeout expected relock"); end
    tests_run++; if (ln !== 1) begin tests_failed++; $display("FAIL short_lost_pulses: got %0d expected 1", ln); end
    tests_run++; if (lat !== 0) begin tests_failed++; $display("FAIL short_locked_at_lost: got %0d expected 0", lat); end
    tests_run++; if (rvf !== lvf + 2) begin tests_failed++; $display("FAIL short_relock_vf: got %0d expected %0d", rvf, lvf + 2); end
    tests_run++; if (rdel !== 3) begin tests_failed++; $display("FAIL short_relock_latency: got %0d expected 3", rdel); end
    tests_run++; if (deb !== 0) begin tests_failed++; $display("FAIL short_de_unlocked: got %0d cycles expected 0", deb); end
    tests_run++; if (line_len !== 10'd40) begin tests_failed++; $display("FAIL short_line_len: got %0d expected 40", line_len); end
  endtask

  task automatic test_frame_change();
    bit to;
    int ln, lvf, ldel, lat, rvf, rdel, deb;
    wait_vfall(1000, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL frame_vf: got timeout expected vsync edge"); end
    gen_frame = 15;
    watch_relock(3000, ln, lvf, ldel, lat, rvf, rdel, deb, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL frame_relock_timeout: got timeout expected relock"); end
    tests_run++; if (ln !== 1) begin tests_failed++; $display("FAIL frame_lost_pulses: got %0d expected 1", ln); end
    tests_run++; if (ldel !== 3) begin tests_failed++; $display("FAIL frame_lost_at_vf: got %0d cycles after vsync expected 3", ldel); end
    tests_run++; if (rvf !== lvf + 2) begin tests_failed++; $display("FAIL frame_relock_vf: got %0d expected %0d", rvf, lvf + 2); end
    tests_run++; if (deb !== 0) begin tests_failed++; $display("FAIL frame_de_unlocked: got %0d cycles expected 0", deb); end
    tests_run++; if (frame_lines !== 11'd15) begin tests_failed++; $display("FAIL frame_lines_new: got %0d expected 15", frame_lines); end
  endtask

  task automatic test_hsync_stuck();
    bit to, seen;
    int ln, lk, wraps, prev, lvf, ldel;
    ln = 0; lk = 0; wraps = 0; seen = 1'b0;
    wait_vfall(1000, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL stuck_vf: got timeout expected vsync edge"); end
    repeat (10) @(posedge clk);
    #1;
    hold_h = 1'b1;
    prev   = int'(px_x);
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      if (lock_lost) begin ln++; seen = 1'b1; end
      else if (seen && locked) lk++;
      if (int'(px_x) < prev) wraps++;
      prev = int'(px_x);
    end
    tests_run++; if (ln !== 1) begin tests_failed++; $display("FAIL stuck_lost_pulses: got %0d expected 1", ln); end
    tests_run++; if (lk !== 0) begin tests_failed++; $display("FAIL stuck_relocked: got %0d locked cycles expected 0", lk); end
    tests_run++; if (wraps !== 0) begin tests_failed++; $display("FAIL stuck_px_x_wrap: got %0d wraps expected 0", wraps); end
    tests_run++; if (px_x !== 10'd1023) begin tests_failed++; $display("FAIL stuck_px_x_sat: got %0d expected 1023", px_x); end
    tests_run++; if (line_len !== 10'd40) begin tests_failed++; $display("FAIL stuck_line_len: got %0d expected 40", line_len); end
    hold_h = 1'b0;
    wait_locked(4000, lvf, ldel, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL stuck_recover: got timeout expected locked"); end
    tests_run++; if (line_len !== 10'd40) begin tests_failed++; $display("FAIL stuck_recover_len: got %0d expected 40", line_len); end
  endtask

  task automatic test_reset_mid_line();
    bit to, found;
    int base, lvf, ldel;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (de && px_y == 11'd5) begin found = 1'b1; break; end
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL midreset_find_active: got timeout expected de on line 5"); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (de !== 1'b0 || {pix_r, pix_g, pix_b} !== 3'b000) begin tests_failed++; $display("FAIL midreset_de_pix: got de=%b pix=%b expected 0 000", de, {pix_r, pix_g, pix_b}); end
    tests_run++; if (locked !== 1'b0 || lock_lost !== 1'b0) begin tests_failed++; $display("FAIL midreset_lock: got locked=%b lost=%b expected 0 0", locked, lock_lost); end
    tests_run++; if (px_x !== 10'd0 || px_y !== 11'd0) begin tests_failed++; $display("FAIL midreset_px: got %0d,%0d expected 0,0", px_x, px_y); end
    tests_run++; if (line_len !== 10'd0 || frame_lines !== 11'd0) begin tests_failed++; $display("FAIL midreset_meas: got %0d,%0d expected 0,0", line_len, frame_lines); end
    tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL midreset_state: got %0d expected 0", dbg_state); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    base  = vfall_cnt;
    wait_locked(3000, lvf, ldel, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL midreset_relock: got timeout expected locked"); end
    tests_run++; if (lvf !== base + 2) begin tests_failed++; $display("FAIL midreset_relock_vf: got %0d expected %0d", lvf, base + 2); end
    tests_run++; if (ldel !== 3) begin tests_failed++; $display("FAIL midreset_relock_latency: got %0d expected 3", ldel); end
    tests_run++; if (frame_lines !== 11'd15) begin tests_failed++; $display("FAIL midreset_frame_lines: got %0d expected 15", frame_lines); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    rgb_r = 1'b1;
    rgb_g = 1'b0;
    rgb_b = 1'b1;
    test_reset();
    test_lock();
    test_active_window();
    test_short_line();
    test_frame_change();
    test_hsync_stuck();
    test_reset_mid_line();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
